// File: rtl/gf163_reduce_if.sv
// rtl/gf163_reduce_if.sv - Handshake bundle between a GF(2^163) product source and the reducer.
interface gf163_reduce_if;
    logic         in_valid;
    logic [324:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [162:0] out_data;
    logic         out_ready;
    logic         busy;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output busy
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  busy
    );
endinterface

// File: rtl/gf163_reduce.sv
// rtl/gf163_reduce.sv - Two-step fold of a 325-bit GF(2) product modulo x^163 + x^7 + x^6 + x^3 + 1.
module gf163_reduce (
    input  logic          clk,
    input  logic          rst,
    gf163_reduce_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FOLD1 = 2'd1,
        FOLD2 = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t       state_q;
    logic [324:0] p_q;
    logic [168:0] t_q;
    logic [162:0] out_data_q;
    logic         out_valid_q;
    logic         in_ready_q;
    logic         busy_q;

    logic [161:0] h1;
    logic [168:0] t_d;
    logic [5:0]   h2;
    logic [162:0] r_d;

    // x^163 == x^7 + x^6 + x^3 + 1, so each high part folds down as H * (1 + x^3 + x^6 + x^7).
    assign h1  = p_q[324:163];
    assign t_d = {6'b0, p_q[162:0]}
               ^ {7'b0, h1}
               ^ {4'b0, h1, 3'b0}
               ^ {1'b0, h1, 6'b0}
               ^ {h1, 7'b0};

    // The first fold leaves at most 6 bits above x^162; folding them once more tops out at x^12.
    assign h2  = t_q[168:163];
    assign r_d = t_q[162:0]
               ^ {157'b0, h2}
               ^ {154'b0, h2, 3'b0}
               ^ {151'b0, h2, 6'b0}
               ^ {150'b0, h2, 7'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            p_q         <= '0;
            t_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        p_q        <= bus.in_data;
                        state_q    <= FOLD1;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                FOLD1: begin
                    t_q     <= t_d;
                    state_q <= FOLD2;
                end
                FOLD2: begin
                    out_data_q  <= r_d;
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    // out_data_q is left untouched so the last result stays visible after the handshake.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;

endmodule
